// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write controller.
//   state_t    : controller FSM state encoding
//   SZ_*       : req_size codes (3 is treated as a word store)
//   is_subword : true for sizes that need a read-modify-write
package store_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores (little-endian lanes).
// Ports:
//   old_word : word captured from memory
//   new_data : store data (byte uses [7:0], half uses [15:0])
//   addr_lo  : byte address bits [1:0]
//   size     : store size code
//   merged   : word to write back
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = new_data;
    case (size)
      SZ_BYTE: begin
        merged = old_word;
        merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
      end
      SZ_HALF: begin
        merged = old_word;
        // addr_lo[0] is ignored: a misaligned half lands on its aligned pair
        if (addr_lo[1]) merged[31:16] = new_data[15:0];
        else            merged[15:0]  = new_data[15:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_rmw_controller.sv
// Store sequencer between the MEM-stage store request and a synchronous
// word-addressed data memory. Word stores are a single write; byte/half
// stores read the word, merge the new lanes and write it back.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : store handshake (ready only in IDLE)
//   req_addr/data/size  : byte address, store data, size code
//   done                : one-cycle pulse with the final write
//   busy                : high in every non-IDLE state
//   mem_en/we/addr/wdata: memory port, mem_addr is a word address
//   mem_rdata           : read data, valid RD_LAT cycles after the read
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | ready for a request; latch it on req_valid
// S_READ  | issue the read of the target word, load wait counter
// S_WAIT  | count down read latency; capture mem_rdata at zero
// S_WRITE | issue the (merged) write, pulse done
module store_rmw_controller
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_tc;
  logic [31:0]       merged;

  assign wait_tc = (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= SZ_WORD;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_valid) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= req_size;
      end
      if (state == S_READ)
        wait_cnt <= CNT_LOAD;
      else if (state == S_WAIT && !wait_tc)
        wait_cnt <= wait_cnt - CNT_W'(1);
      if (state == S_WAIT && wait_tc)
        rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    busy       = 1'b1;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req_valid)
          state_next = is_subword(req_size) ? S_READ : S_WRITE;
      end
      S_READ: begin
        mem_en     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_tc) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Gated by reset so the pipeline never sees a handshake that reset discards.
  assign req_ready = (state == S_IDLE) && !reset;

  // Address and data are held at zero outside an access so the port is quiet.
  assign mem_addr  = mem_en ? addr_q[ADDR_W-1:2] : '0;
  assign mem_wdata = mem_we ? merged : '0;

  store_lane_merge u_merge (
    .old_word (rdata_q),
    .new_data (data_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .merged   (merged)
  );

endmodule

// File: tb/tb_store_rmw_controller.sv
module tb_store_rmw_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid1, req_valid3;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;

  logic        ready1, done1, busy1, en1, we1;
  logic [29:0] maddr1;
  logic [31:0] wdata1, rdata1;
  logic        ready3, done3, busy3, en3, we3;
  logic [29:0] maddr3;
  logic [31:0] wdata3, rdata3;

  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] p0, p1, p2;
  logic        pv0, pv1, pv2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_rmw_controller #(.ADDR_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(ready1),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done1), .busy(busy1), .mem_en(en1), .mem_we(we1),
    .mem_addr(maddr1), .mem_wdata(wdata1), .mem_rdata(rdata1)
  );

  store_rmw_controller #(.ADDR_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(ready3),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done3), .busy(busy3), .mem_en(en3), .mem_we(we3),
    .mem_addr(maddr3), .mem_wdata(wdata3), .mem_rdata(rdata3)
  );

  // Read models: data is only valid exactly RD_LAT cycles after the read.
  always @(posedge clk)
    rdata1 <= (en1 && !we1) ? mem1[maddr1[5:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    p0  <= mem3[maddr3[5:0]];
    pv0 <= en3 && !we3;
    p1  <= p0;  pv1 <= pv0;
    p2  <= p1;  pv2 <= pv1;
  end
  assign rdata3 = pv2 ? p2 : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] init;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 2'd0, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0102, 32'h0000_00AB, 2'd1, 32'h1122_3344, 32'h11AB_3344};
    vecs[2] = '{32'h0000_0103, 32'h0000_CAFE, 2'd2, 32'h1122_3344, 32'hCAFE_3344};
    vecs[3] = '{32'h0000_0100, 32'h0000_CAFE, 2'd2, 32'h1122_3344, 32'h1122_CAFE};
    vecs[4] = '{32'h0000_0201, 32'hFFFF_FF55, 2'd1, 32'hAABB_CCDD, 32'hAABB_55DD};
    vecs[5] = '{32'h0000_0203, 32'h0000_0099, 2'd1, 32'h0000_0000, 32'h9900_0000};
    vecs[6] = '{32'h0000_0204, 32'h0123_4567, 2'd3, 32'hFFFF_FFFF, 32'h0123_4567};
    vecs[7] = '{32'h0000_0202, 32'hABCD_1234, 2'd2, 32'h5566_7788, 32'h1234_7788};

    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end

    reset = 1'b1; req_valid1 = 1'b0; req_valid3 = 1'b0;
    req_addr = '0; req_data = '0; req_size = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", ready1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_en", en1, 0);
    chk("rst_done", done1, 0);
    chk("rst_addr", {2'b0, maddr1}, 0);
    chk("rst_wdata", wdata1, 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", ready1, 1);

    // Table-driven single stores, RD_LAT=1
    for (int i = 0; i < 8; i++) begin
      mem1[vecs[i].addr[7:2]] = vecs[i].init;
      @(negedge clk);
      req_addr = vecs[i].addr; req_data = vecs[i].data; req_size = vecs[i].size;
      req_valid1 = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), ready1, 1);
      @(negedge clk);
      // inputs after acceptance must be ignored
      req_valid1 = 1'b0; req_data = ~req_data; req_addr = req_addr ^ 32'h4; req_size = ~req_size;
      chk($sformatf("v%0d_busy", i), busy1, 1);
      chk($sformatf("v%0d_rdy_lo", i), ready1, 0);
      if (vecs[i].size == 2'd1 || vecs[i].size == 2'd2) begin
        chk($sformatf("v%0d_rd_en", i), {en1, we1, done1}, 3'b100);
        chk($sformatf("v%0d_rd_addr", i), {2'b0, maddr1}, {2'b0, vecs[i].addr[31:2]});
        @(negedge clk);
        chk($sformatf("v%0d_wait", i), {busy1, en1, done1}, 3'b100);
        @(negedge clk);
      end
      chk($sformatf("v%0d_wr_ctl", i), {en1, we1, done1}, 3'b111);
      chk($sformatf("v%0d_wr_addr", i), {2'b0, maddr1}, {2'b0, vecs[i].addr[31:2]});
      chk($sformatf("v%0d_wdata", i), wdata1, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("v%0d_after", i), {ready1, busy1, done1, en1}, 4'b1000);
    end

    // RD_LAT=3 byte store at address 0
    mem3[0] = 32'h1122_3344;
    @(negedge clk);
    req_addr = 32'h0; req_data = 32'h0000_00FF; req_size = 2'd1; req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0; req_data = 32'h0;
    chk("l3_read", {busy3, en3, we3, done3}, 4'b1100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("l3_wait%0d", c), {busy3, en3, done3}, 3'b100);
    end
    @(negedge clk);
    chk("l3_write", {busy3, en3, we3, done3}, 4'b1111);
    chk("l3_wdata", wdata3, 32'h1122_33FF);
    @(negedge clk);
    chk("l3_after", {ready3, busy3, done3}, 3'b100);

    // Reset in WAIT: no write, no done afterwards
    mem1[5] = 32'h5555_5555;
    @(negedge clk);
    req_addr = 32'h0000_0014; req_data = 32'h0000_0066; req_size = 2'd1; req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("rw_read", {en1, we1}, 2'b10);
    @(negedge clk);
    chk("rw_inwait", {busy1, en1}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_idle", {ready1, busy1, en1, we1, done1}, 5'b10000);
    chk("rw_addr", {2'b0, maddr1}, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rw_nowr%0d", c), {we1, done1, busy1}, 3'b000);
    end

    // req_valid together with reset: not accepted
    @(negedge clk);
    reset = 1'b1; req_valid1 = 1'b1; req_size = 2'd0;
    @(negedge clk);
    reset = 1'b0; req_valid1 = 1'b0;
    #1;
    chk("rv_not_acc", {busy1, en1, done1}, 3'b000);

    // Back-to-back: sw then sb, valid held continuously
    mem1[3] = 32'h0102_0304;
    @(negedge clk);
    req_addr = 32'h0000_0108; req_data = 32'hA5A5_A5A5; req_size = 2'd0; req_valid1 = 1'b1;
    @(negedge clk);
    chk("bb_sw", {en1, we1, done1, ready1}, 4'b1110);
    chk("bb_sw_data", wdata1, 32'hA5A5_A5A5);
    req_addr = 32'h0000_010C; req_data = 32'h0000_0077; req_size = 2'd1;
    @(negedge clk);
    chk("bb_accept", {ready1, busy1}, 2'b10);
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("bb_read", {ready1, en1, we1}, 3'b010);
    chk("bb_raddr", {2'b0, maddr1}, 32'h43);
    @(negedge clk);
    chk("bb_wait", {ready1, busy1}, 2'b01);
    @(negedge clk);
    chk("bb_write", {ready1, en1, we1, done1}, 4'b0111);
    chk("bb_wdata", wdata1, 32'h0102_0377);
    @(negedge clk);
    chk("bb_end", {ready1, busy1}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
